// File: rtl/alu_regfile_flags_if.sv
// Bus bundle between the ALU sequencing logic (master) and the architectural
// state block (slave): operand reads, writeback, and flag-stack control.
interface alu_regfile_flags_if #(
    parameter int AW = 3,
    parameter int CW = 3
);
    logic [AW-1:0] rd_a_addr;
    logic [AW-1:0] rd_b_addr;
    logic [7:0]    a_out;
    logic [7:0]    b_out;
    logic [3:0]    flags_out;
    logic          wb_valid;
    logic          wb_reg_en;
    logic [AW-1:0] wb_addr;
    logic [7:0]    wb_data;
    logic [3:0]    wb_flags;
    logic [3:0]    wb_flag_mask;
    logic          flag_push;
    logic          flag_pop;
    logic [CW-1:0] stk_count;
    logic          stk_err;
    logic          err_clr;

    modport master (
        output rd_a_addr, rd_b_addr, wb_valid, wb_reg_en, wb_addr, wb_data,
               wb_flags, wb_flag_mask, flag_push, flag_pop, err_clr,
        input  a_out, b_out, flags_out, stk_count, stk_err
    );

    modport slave (
        input  rd_a_addr, rd_b_addr, wb_valid, wb_reg_en, wb_addr, wb_data,
               wb_flags, wb_flag_mask, flag_push, flag_pop, err_clr,
        output a_out, b_out, flags_out, stk_count, stk_err
    );
endinterface

// File: rtl/alu_regfile_flags.sv
// ALU architectural state: register file with two combinational read ports,
// {C,S,V,Z} status register with masked writeback, and a LIFO flag save stack.
module alu_regfile_flags #(
    parameter int NUM_REGS    = 8,
    parameter int AW          = 3,
    parameter int STACK_DEPTH = 4,
    parameter int ZERO_R0     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_regfile_flags_if.slave   bus
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic [NUM_REGS-1:0][7:0]    reg_q;
    logic [STACK_DEPTH-1:0][3:0] stk_q;

    logic [3:0]    flags_reg, flags_next;
    logic [CW-1:0] sp_reg, sp_next;
    logic          stk_err_reg, stk_err_next;

    logic push_req, pop_req, both_req;
    logic push_ok, pop_ok, err_set;
    logic [3:0] top_flags;

    genvar gi;

    // Register file: each register is its own flop so reset clears everything at once.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (ZERO_R0 != 0 && gi == 0) begin : g_zero
                assign reg_q[gi] = 8'h00;
            end else begin : g_live
                logic [7:0] data_reg;
                logic       wr_en;
                assign wr_en = bus.wb_valid & bus.wb_reg_en & (bus.wb_addr == AW'(gi));
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= 8'h00;
                    end else if (wr_en) begin
                        data_reg <= bus.wb_data;
                    end
                end
                assign reg_q[gi] = data_reg;
            end
        end

        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stk
            logic [3:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= 4'h0;
                end else if (push_ok && sp_reg == CW'(gi)) begin
                    entry_reg <= flags_reg;
                end
            end
            assign stk_q[gi] = entry_reg;
        end
    endgenerate

    // A simultaneous push and pop is a protocol error; neither side takes effect.
    always_comb begin
        both_req  = bus.flag_push & bus.flag_pop;
        push_req  = bus.flag_push & ~bus.flag_pop;
        pop_req   = bus.flag_pop & ~bus.flag_push;
        push_ok   = push_req && (sp_reg != CW'(STACK_DEPTH));
        pop_ok    = pop_req && (sp_reg != '0);
        err_set   = both_req | (push_req & ~push_ok) | (pop_req & ~pop_ok);

        top_flags = 4'h0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_reg == CW'(i + 1)) begin
                top_flags = stk_q[i];
            end
        end

        sp_next = sp_reg;
        if (push_ok) begin
            sp_next = sp_reg + CW'(1);
        end else if (pop_ok) begin
            sp_next = sp_reg - CW'(1);
        end

        // A pop overrides every flag bit of a concurrent writeback.
        flags_next = flags_reg;
        if (bus.wb_valid) begin
            flags_next = (flags_reg & ~bus.wb_flag_mask) | (bus.wb_flags & bus.wb_flag_mask);
        end
        if (pop_ok) begin
            flags_next = top_flags;
        end

        stk_err_next = stk_err_reg;
        if (err_set) begin
            stk_err_next = 1'b1;
        end else if (bus.err_clr) begin
            stk_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg   <= 4'h0;
            sp_reg      <= '0;
            stk_err_reg <= 1'b0;
        end else begin
            flags_reg   <= flags_next;
            sp_reg      <= sp_next;
            stk_err_reg <= stk_err_next;
        end
    end

    // No write-to-read bypass: keeps the ALU operand path free of a loop.
    assign bus.a_out     = reg_q[bus.rd_a_addr];
    assign bus.b_out     = reg_q[bus.rd_b_addr];
    assign bus.flags_out = flags_reg;
    assign bus.stk_count = sp_reg;
    assign bus.stk_err   = stk_err_reg;
endmodule

// File: doc/alu_regfile_flags.md
Name: alu_regfile_flags

Overview:
- Architectural state block directly upstream and downstream of the 8-bit ALU.
- Holds the general-purpose register file; its two combinational read ports drive ALU operands a_in/b_in.
- Holds the 4-bit status register {C,S,V,Z}, which drives ALU status_in.
- Captures ALU result_out/status_out at writeback, and provides a small flag save stack for call/interrupt sequencing.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; power of two, 2..16.
- AW, 3, register address width = log2(NUM_REGS).
- STACK_DEPTH, 4, entries in the flag save stack; 1..8.
- ZERO_R0, 0, when 1, register 0 reads as 8'h00 and ignores writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_a_addr  in  AW  read port A address.
- rd_b_addr  in  AW  read port B address.
- a_out  out  8  register[rd_a_addr], to ALU a_in.
- b_out  out  8  register[rd_b_addr], to ALU b_in.
- flags_out  out  4  status register {C,S,V,Z}, to ALU status_in.
- wb_valid  in  1  writeback strobe for this cycle.
- wb_reg_en  in  1  with wb_valid: write wb_data to wb_addr.
- wb_addr  in  AW  destination register.
- wb_data  in  8  ALU result_out.
- wb_flags  in  4  ALU status_out {C,S,V,Z}.
- wb_flag_mask  in  4  per-bit flag update enable, same bit order.
- flag_push  in  1  push flags_out onto the stack.
- flag_pop  in  1  pop the stack into the status register.
- stk_count  out  log2(STACK_DEPTH)+1  occupied stack entries.
- stk_err  out  1  sticky stack overflow/underflow flag.
- err_clr  in  1  clears stk_err.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asserted immediately, independent of clk):
  - All registers = 8'h00; a_out/b_out therefore read 8'h00.
  - Status register = 4'h0.
  - Stack pointer = 0, so stk_count = 0; all stack entries = 4'h0.
  - stk_err = 0.
  - Reset mid-operation discards any in-flight write, push or pop.
- Reads:
  - Purely combinational from registered state; no write-to-read bypass.
  - A write at edge N is visible on a_out/b_out after edge N.
  - No bypass is intentional: it avoids a combinational loop through the ALU.
  - Out-of-range addresses are impossible for power-of-two NUM_REGS.
  - With ZERO_R0=1, address 0 reads 8'h00.
- Register write: at the rising edge when wb_valid && wb_reg_en, reg[wb_addr] <= wb_data.
  - Write to r0 with ZERO_R0=1 is dropped silently.
- Flag update: at the rising edge when wb_valid, each bit i is updated independently:
  - flags[i] <= wb_flag_mask[i] ? wb_flags[i] : flags[i].
  - wb_valid=0: no register or flag change, regardless of the other wb_* inputs.
- Flag stack: LIFO, STACK_DEPTH entries, pointer-based. Push and pop take effect on the edge.
  - Push, not full: entry[sp] <= current flags_out (the pre-edge value); sp <= sp+1.
  - Push when full (sp == STACK_DEPTH): no change to entries or sp; stk_err <= 1.
  - Pop, not empty: status register <= entry[sp-1]; sp <= sp-1.
  - Pop when empty: status register unchanged; stk_err <= 1.
- Simultaneous events:
  - push && pop together: both ignored and stk_err <= 1; treated as a protocol error.
  - pop with a wb_valid flag update: pop wins for all four flag bits. The register-file write still occurs.
  - push with a wb_valid flag update: pushed value is the pre-edge flags; the status register then takes the masked wb_flags.
  - err_clr with a new error on the same edge: set wins, stk_err stays 1.
- stk_count = sp, combinational from the pointer register.
- Latency:
  - Write to read-visible: 1 cycle.
  - Pop to flags_out: 1 cycle.
  - No stalls and no ready signal; every strobe is accepted in its cycle.

Test Plan:
- Reset/readback: release rst_n, then write r3=8'hA5 and r5=8'h3C on consecutive cycles. Set rd_a_addr=3, rd_b_addr=5 -> a_out=8'hA5, b_out=8'h3C, flags_out=4'h0.
- No bypass: write r2=8'h7F with rd_a_addr=2 in the same cycle -> a_out stays 8'h00 before the edge and reads 8'h7F after it.
- Masked flags: wb_valid=1, wb_flags=4'b1011, wb_flag_mask=4'b1001, reg_en=0 -> flags_out=4'b1001; no register changes.
- Stack full/empty: with STACK_DEPTH=4, push flags 1,2,3,4, then a fifth push -> stk_count=4 and stk_err=1. Four pops restore 4,3,2,1. A fifth pop -> flags stay 1, stk_err=1. err_clr -> stk_err=0.
- Simultaneous:
  - Push plus flag write (mask 4'hF, wb_flags=4'h6) from flags 4'h9 -> entry=4'h9, flags_out=4'h6.
  - Pop plus flag write -> flags_out equals the popped value.
  - push && pop -> sp unchanged, stk_err=1.
- Async reset mid-stream: assert rst_n low between clock edges with sp=2 and r1=8'h11 -> all outputs go to their reset values without waiting for a clock edge.
- ZERO_R0=1: write r0=8'hFF -> a_out at address 0 reads 8'h00.
